// File: rtl/io_stim_seq.sv
// Table-driven stimulus player for io_rdata: plays up to DEPTH {word, hold} entries after start,
// with optional looping, pause and abort.
module io_stim_seq #(
    parameter int                DATA_W    = 24,
    parameter int                DEPTH     = 16,
    parameter int                DLY_W     = 24,
    parameter int                START_DLY = 0,
    parameter logic [DATA_W-1:0] IDLE_WORD = '0,
    localparam int               AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              fpga_rst,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_word,
    input  logic [DLY_W-1:0]  load_dly,
    input  logic [AW:0]       seq_len,
    input  logic              loop_mode,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    output logic [DATA_W-1:0] io_rdata,
    output logic [AW-1:0]     step_idx,
    output logic              step_strobe,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [DLY_W-1:0] START_CNT = DLY_W'(START_DLY);
    localparam logic [AW:0]      DEPTH_LEN = (AW+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [DLY_W-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                strobe_q, strobe_d;
    logic [AW:0]         len_q, len_d;
    logic                loop_q, loop_d;

    logic [DATA_W-1:0]   tbl_word_q [DEPTH];
    logic [DLY_W-1:0]    tbl_dly_q  [DEPTH];

    logic                apply;
    logic [AW-1:0]       apply_idx;
    logic [AW:0]         len_clamp;
    logic [AW:0]         last_idx;
    logic                table_open;

    assign table_open = (state_q == S_IDLE) || (state_q == S_DONE);
    assign len_clamp  = (seq_len > DEPTH_LEN) ? DEPTH_LEN : seq_len;
    assign last_idx   = len_q - (AW+1)'(1);

    // Table storage is deliberately outside the reset domain so a reset keeps the loaded program.
    always_ff @(posedge clk) begin
        if (load_en && table_open) begin
            tbl_word_q[load_addr] <= load_word;
            tbl_dly_q[load_addr]  <= load_dly;
        end
    end

    always_ff @(posedge clk or posedge fpga_rst) begin
        if (fpga_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            rdata_q  <= IDLE_WORD;
            strobe_q <= 1'b0;
            len_q    <= '0;
            loop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rdata_q  <= rdata_d;
            strobe_q <= strobe_d;
            len_q    <= len_d;
            loop_q   <= loop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rdata_d   = rdata_q;
        strobe_d  = 1'b0;
        len_d     = len_q;
        loop_d    = loop_q;
        apply     = 1'b0;
        apply_idx = '0;

        if (abort) begin
            state_d = S_IDLE;
            rdata_d = IDLE_WORD;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len_d  = len_clamp;
                        loop_d = loop_mode;
                        if (len_clamp == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_PRE;
                            cnt_d   = START_CNT;
                        end
                    end
                end
                S_PRE: begin
                    if (!pause) begin
                        if (cnt_q == '0) apply = 1'b1;
                        else             cnt_d = cnt_q - DLY_W'(1);
                    end
                end
                S_HOLD: begin
                    if (!pause) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - DLY_W'(1);
                        end else if ({1'b0, idx_q} != last_idx) begin
                            apply     = 1'b1;
                            apply_idx = idx_q + AW'(1);
                        end else if (loop_q) begin
                            apply = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Hold of 0 behaves as 1, so the reload value saturates at zero.
        if (apply) begin
            state_d  = S_HOLD;
            idx_d    = apply_idx;
            rdata_d  = tbl_word_q[apply_idx];
            cnt_d    = (tbl_dly_q[apply_idx] == '0) ? '0 : tbl_dly_q[apply_idx] - DLY_W'(1);
            strobe_d = 1'b1;
        end
    end

    assign io_rdata    = rdata_q;
    assign step_idx    = idx_q;
    assign step_strobe = strobe_q && !pause;
    assign busy        = (state_q == S_PRE) || (state_q == S_HOLD);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_io_stim_seq.sv
// Directed bench for io_stim_seq: timing of a 4-entry table, loop, pause, abort, reset and boundary holds.
module tb_io_stim_seq;

    logic        clk = 1'b0;
    logic        fpga_rst;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [23:0] load_word;
    logic [23:0] load_dly;
    logic [4:0]  seq_len;
    logic        loop_mode, start, pause, abort;
    logic [23:0] io_rdata;
    logic [3:0]  step_idx;
    logic        step_strobe, busy, done;

    int checks = 0;
    int errors = 0;

    io_stim_seq dut (
        .clk(clk), .fpga_rst(fpga_rst),
        .load_en(load_en), .load_addr(load_addr), .load_word(load_word), .load_dly(load_dly),
        .seq_len(seq_len), .loop_mode(loop_mode), .start(start), .pause(pause), .abort(abort),
        .io_rdata(io_rdata), .step_idx(step_idx), .step_strobe(step_strobe),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [23:0] w, input logic [23:0] d);
        load_en = 1'b1; load_addr = a; load_word = w; load_dly = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic run_plain(input string tag);
        int nstb;
        seq_len = 5'd4; loop_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        nstb = 0;
        chk({tag, "_pre_busy"}, 32'(busy), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            nstb += int'(step_strobe);
            case (k)
                1: begin
                    chk({tag, "_w0"}, 32'(io_rdata), 32'h020078);
                    chk({tag, "_idx0"}, 32'(step_idx), 32'd0);
                    chk({tag, "_stb0"}, 32'(step_strobe), 32'd1);
                end
                3:  chk({tag, "_w0_hold"}, 32'(io_rdata), 32'h020078);
                4: begin
                    chk({tag, "_w1"}, 32'(io_rdata), 32'h800000);
                    chk({tag, "_idx1"}, 32'(step_idx), 32'd1);
                end
                8:  chk({tag, "_w1_hold"}, 32'(io_rdata), 32'h800000);
                9:  chk({tag, "_w2"}, 32'(io_rdata), 32'h400008);
                11: begin
                    chk({tag, "_w3"}, 32'(io_rdata), 32'hC00001);
                    chk({tag, "_idx3"}, 32'(step_idx), 32'd3);
                end
                14: chk({tag, "_busy14"}, 32'(busy), 32'd1);
                15: begin
                    chk({tag, "_done"}, 32'(done), 32'd1);
                    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
                    chk({tag, "_done_word"}, 32'(io_rdata), 32'hC00001);
                end
                16: chk({tag, "_done_hold"}, 32'(io_rdata), 32'hC00001);
                default: ;
            endcase
        end
        chk({tag, "_nstrobe"}, 32'(nstb), 32'd4);
    endtask

    initial begin
        int nstb;
        logic [3:0] seq_idx [$];

        fpga_rst = 1'b1; load_en = 1'b0; load_addr = '0; load_word = '0; load_dly = '0;
        seq_len = '0; loop_mode = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
        #12;
        chk("rst_rdata", 32'(io_rdata), 32'h0);
        chk("rst_idx", 32'(step_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_strobe", 32'(step_strobe), 32'd0);
        tick();
        fpga_rst = 1'b0;
        tick();

        load(4'd0, 24'h020078, 24'd3);
        load(4'd1, 24'h800000, 24'd5);
        load(4'd2, 24'h400008, 24'd2);
        load(4'd3, 24'hC00001, 24'd4);

        run_plain("run1");

        // abort wins over a simultaneous start in DONE
        abort = 1'b1; start = 1'b1; seq_len = 5'd4;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_rdata", 32'(io_rdata), 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_idx", 32'(step_idx), 32'd0);
        tick();
        chk("abort_stays_idle", 32'(busy), 32'd0);

        seq_len = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_strobe", 32'(step_strobe), 32'd0);
        chk("len0_rdata", 32'(io_rdata), 32'h0);
        chk("len0_busy", 32'(busy), 32'd0);

        // looping run
        seq_len = 5'd4; loop_mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (step_strobe) seq_idx.push_back(step_idx);
            if (k == 15) begin
                chk("loop_w0_again", 32'(io_rdata), 32'h020078);
                chk("loop_stb15", 32'(step_strobe), 32'd1);
            end
        end
        chk("loop_busy", 32'(busy), 32'd1);
        chk("loop_nstrobe", 32'(seq_idx.size()), 32'd9);
        if (seq_idx.size() >= 6) begin
            chk("loop_seq0", 32'(seq_idx[0]), 32'd0);
            chk("loop_seq1", 32'(seq_idx[1]), 32'd1);
            chk("loop_seq2", 32'(seq_idx[2]), 32'd2);
            chk("loop_seq3", 32'(seq_idx[3]), 32'd3);
            chk("loop_seq4", 32'(seq_idx[4]), 32'd0);
            chk("loop_seq5", 32'(seq_idx[5]), 32'd1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        loop_mode = 1'b0;
        chk("loop_abort_busy", 32'(busy), 32'd0);

        // asynchronous reset in the middle of a HOLD
        seq_len = 5'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid_w0", 32'(io_rdata), 32'h020078);
        #2;
        fpga_rst = 1'b1;
        #1;
        chk("async_rdata", 32'(io_rdata), 32'h0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_idx", 32'(step_idx), 32'd0);
        chk("async_strobe", 32'(step_strobe), 32'd0);
        tick();
        fpga_rst = 1'b0;
        tick();
        run_plain("rerun");

        // pause for 7 cycles during entry 1, with an ignored write to entry 2
        seq_len = 5'd4; start = 1'b1;
        tick();
        start = 1'b0;
        nstb = 0;
        for (int k = 1; k <= 23; k++) begin
            tick();
            if (k >= 6 && k <= 12) begin
                nstb += int'(step_strobe);
                chk("pause_hold_word", 32'(io_rdata), 32'h800000);
            end
            if (k == 9)  chk("pause_no_w2", 32'(io_rdata), 32'h800000);
            if (k == 15) chk("pause_w1_late", 32'(io_rdata), 32'h800000);
            if (k == 16) begin
                chk("pause_w2", 32'(io_rdata), 32'h400008);
                chk("pause_stb_w2", 32'(step_strobe), 32'd1);
            end
            if (k == 22) chk("pause_done", 32'(done), 32'd1);
            if (k == 5) begin
                pause = 1'b1;
                load_en = 1'b1; load_addr = 4'd2; load_word = 24'hFFFFFF; load_dly = 24'd1;
            end
            if (k == 12) begin
                pause = 1'b0;
                load_en = 1'b0;
            end
        end
        chk("pause_no_strobe", 32'(nstb), 32'd0);

        // zero hold entry, with write to entry 0 on the same edge as start
        load(4'd1, 24'h222222, 24'd2);
        load_en = 1'b1; load_addr = 4'd0; load_word = 24'h111111; load_dly = 24'd0;
        seq_len = 5'd2; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        tick();
        chk("dly0_w0", 32'(io_rdata), 32'h111111);
        chk("dly0_stb0", 32'(step_strobe), 32'd1);
        tick();
        chk("dly0_w1", 32'(io_rdata), 32'h222222);
        chk("dly0_stb1", 32'(step_strobe), 32'd1);
        chk("dly0_idx1", 32'(step_idx), 32'd1);
        tick();
        chk("dly0_w1_hold", 32'(io_rdata), 32'h222222);
        chk("dly0_stb_off", 32'(step_strobe), 32'd0);
        chk("dly0_busy", 32'(busy), 32'd1);
        tick();
        chk("dly0_done", 32'(done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
